sentinel_guard_ctrl: RTL and testbench
======================================

# sentinel_guard_ctrl

Tamper-response controller for the Citadel glitch-detection datapath (Gerlinsky Guard). It synchronizes the raw glitch-sensor lines from the buffer-chain detectors and counts glitch events in a leaky window. When the count reaches threshold, it sequences a timed Tactical Wipe strobe onto the reset pins of the protected DFFR state cells, then holds the design in lockout until cooldown completes and the host acknowledges.

## Interface
- `N_SENSE`, 4: number of glitch-sensor inputs (1–8).
- `THRESH`, 3: event count that triggers a wipe (1–15).
- `WINDOW`, 64: leak period in cycles; one count decays per period (≥2).
- `WIPE_CYC`, 8: wipe strobe length in cycles (≥1).
- `COOL_CYC`, 256: lockout cooldown in cycles before `ack` is honoured (≥1).
- `clk`  in  1  system clock.
- `r`  in  1  reset; one clock, synchronous, active-high.
- `arm`  in  1  level; enables monitoring.
- `sense`  in  N_SENSE  raw asynchronous glitch-detector outputs, active-high.
- `force`  in  1  single-cycle pulse; host-forced wipe.
- `ack`  in  1  single-cycle pulse; host rearm request from lockout.
- `wipe`  out  1  registered wipe strobe to the protected cells' `r` pins.
- `alert`  out  1  registered; high when `evt_count != 0` in ARMED.
- `locked`  out  1  registered; high in LOCKOUT.
- `state`  out  2  current FSM state encoding.
- `evt_count`  out  4  current event count.

## Operation
- States: IDLE=0, ARMED=1, WIPE=2, LOCKOUT=3.
- Sensor path: each `sense` bit passes through a 2-flop synchronizer followed by a rising-edge detect. `event` = OR of all edges. Simultaneous edges on several bits count as one event.
- IDLE: `evt_count`=0. `arm`=1 moves to ARMED on the next cycle. `force`=1 moves to WIPE.
- ARMED:
  - An event increments `evt_count` (saturates at 15).
  - The leak timer counts WINDOW cycles, then restarts. At its terminal cycle with no event, a nonzero `evt_count` decrements. An event coinciding with the terminal cycle leaves the count unchanged.
  - If the next count ≥ THRESH, or `force`=1, go to WIPE.
  - `arm`=0 goes to IDLE and clears the count, unless a wipe trigger occurs in the same cycle; the wipe wins.
- WIPE: `wipe`=1 for exactly WIPE_CYC cycles, then go to LOCKOUT. `arm`, `ack`, `force` and events are ignored. `evt_count` clears on entry.
- LOCKOUT:
  - Cooldown counter runs COOL_CYC cycles.
  - `ack` after cooldown expires goes to IDLE. `ack` before expiry is ignored and is not remembered.
  - `force` restarts WIPE, and the cooldown restarts at the next LOCKOUT entry.
- Leak timer and cooldown counter reset to 0 on every state entry.

## Timing
- Reset:
  - state=IDLE; `wipe`, `alert`, `locked` = 0; `evt_count`=0.
  - Synchronizer and edge flops = 0.
  - Event detection is masked for the first 3 cycles after `r` deasserts, so a sensor already high at reset release does not count.
- Sense-to-event latency: 3 cycles (2 sync + edge register).
- Trigger to wipe: `wipe` rises on the first cycle after the triggering event or `force` cycle.
- `wipe` falls exactly WIPE_CYC cycles later. `locked` rises in that same cycle.
- `ack` in LOCKOUT: `locked` falls the next cycle. `arm` held high reaches ARMED one cycle after that.
- `r` asserted mid-wipe: `wipe` drops on the next edge. This is intentional; external reset overrides.

## Configuration
- `CITADEL_SENTINEL_LATCH_EN` defined:
  - LOCKOUT is terminal; `ack` is ignored; only `r` exits.
  - `force` in LOCKOUT is ignored.
  - The cooldown counter is removed.
- Undefined: cooldown/`ack` rearm behaviour as above.

## Structure
- Shared package `citadel_pkg`: state enum (IDLE/ARMED/WIPE/LOCKOUT), the 2-bit state encoding constants, and the 4-bit count width constant.
- Sub-module `sentinel_glitch_sync`:
  - N_SENSE-wide 2-flop synchronizer, edge detect and post-reset 3-cycle mask.
  - Output is a single `event` bit.
  - Marked `keep_hierarchy` like the other Citadel cells.
- FSM, leak timer, wipe counter and cooldown counter live in the top level.

## Test plan
- Reset, arm, 3 single-cycle `sense[0]` pulses 5 cycles apart -> `alert` after the first; `wipe` high exactly 8 cycles starting 4 cycles after the third pulse; then `locked`=1.
- Arm, 2 events, wait 128 idle cycles -> `evt_count` 2→1→0; `alert` falls; no wipe.
- `sense`=4'b1111 rising together ×2, then one more rise -> counts 1, 2, 3; wipe on the third.
- In LOCKOUT, `ack` at cycle 100 -> ignored; `ack` at cycle 257 -> IDLE next cycle, `locked`=0.
- `force` pulse in IDLE and in LOCKOUT -> 8-cycle wipe each time; `r` asserted at wipe cycle 3 -> `wipe`=0 next edge, state=IDLE.
- `sense[1]` held high through reset release -> no event. With `CITADEL_SENTINEL_LATCH_EN` defined, `ack` after 1000 cycles -> remains LOCKOUT.

Source files
------------

// File: rtl/citadel_pkg.sv
// citadel_pkg: shared types and constants for the Citadel guard cells.
// Holds the controller state enum, its 2-bit encoding and the event-count width.
package citadel_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_ARMED   = 2'd1;
    localparam logic [1:0] ENC_WIPE    = 2'd2;
    localparam logic [1:0] ENC_LOCKOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ENC_IDLE,
        ST_ARMED   = ENC_ARMED,
        ST_WIPE    = ENC_WIPE,
        ST_LOCKOUT = ENC_LOCKOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment used by the event counter so it parks at its maximum.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sentinel_glitch_sync.sv
// sentinel_glitch_sync: brings the raw glitch-detector lines into the clock
// domain, detects rising edges and merges them into one registered event bit.
// Edges are masked for the first three cycles after reset so a sensor that is
// already high when reset releases does not look like a fresh glitch.
(* keep_hierarchy = "yes" *)
module sentinel_glitch_sync
    import citadel_pkg::*;
#(
    parameter int N_SENSE = 4
) (
    input  logic               i_clk,
    input  logic               i_r,
    input  logic [N_SENSE-1:0] i_sense,
    output logic               o_event
);

    logic [N_SENSE-1:0] r_sync1;
    logic [N_SENSE-1:0] r_sync2;
    logic [N_SENSE-1:0] r_prev;
    logic [1:0]         r_maskCnt;
    logic               r_event;

    // Two-flop synchronizer, previous-value flop for edge detect, reset mask and
    // the registered OR of all rising edges (several bits at once are one event).
    always_ff @(posedge i_clk) begin
        if (i_r) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_maskCnt <= 2'd0;
            r_event   <= 1'b0;
        end else begin
            r_sync1 <= i_sense;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_maskCnt != 2'd3) begin
                r_maskCnt <= r_maskCnt + 2'd1;
            end
            r_event <= (r_maskCnt == 2'd3) && (|(r_sync2 & ~r_prev));
        end
    end

    assign o_event = r_event;

endmodule

// File: rtl/sentinel_guard_ctrl.sv
// sentinel_guard_ctrl: Citadel tamper-response controller (Gerlinsky Guard).
// Counts glitch events in a leaky window; at threshold or on a host force it
// drives a timed wipe strobe onto the protected cells, then holds lockout.
// Build option CITADEL_SENTINEL_LATCH_EN: lockout becomes terminal (only reset
// leaves it), ack and force are ignored there and the cooldown counter is gone.
module sentinel_guard_ctrl
    import citadel_pkg::*;
#(
    parameter int N_SENSE  = 4,
    parameter int THRESH   = 3,
    parameter int WINDOW   = 64,
    parameter int WIPE_CYC = 8,
    parameter int COOL_CYC = 256
) (
    input  logic               i_clk,
    input  logic               i_r,
    input  logic               i_arm,
    input  logic [N_SENSE-1:0] i_sense,
    input  logic               i_force,
    input  logic               i_ack,
    output logic               o_wipe,
    output logic               o_alert,
    output logic               o_locked,
    output logic [1:0]         o_state,
    output logic [CNT_W-1:0]   o_evt_count
);

    localparam int LEAK_W = $clog2(WINDOW);
    localparam int WIPE_W = (WIPE_CYC > 1) ? $clog2(WIPE_CYC) : 1;

    localparam logic [LEAK_W-1:0] LEAK_LAST = LEAK_W'(WINDOW - 1);
    localparam logic [WIPE_W-1:0] WIPE_LAST = WIPE_W'(WIPE_CYC - 1);
    localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);

`ifndef CITADEL_SENTINEL_LATCH_EN
    localparam int COOL_W = $clog2(COOL_CYC + 1);
    localparam logic [COOL_W-1:0] COOL_DONE = COOL_W'(COOL_CYC);

    logic [COOL_W-1:0] r_coolCnt;
    logic              w_coolDone;
`endif

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [LEAK_W-1:0]  r_leakCnt;
    logic [WIPE_W-1:0]  r_wipeCnt;
    logic               r_wipe;
    logic               r_alert;
    logic               r_locked;

    logic               w_event;
    logic               w_leakTerm;
    logic [CNT_W-1:0]   w_countNext;
    logic               w_trigger;

    sentinel_glitch_sync #(
        .N_SENSE (N_SENSE)
    ) u_glitchSync (
        .i_clk   (i_clk),
        .i_r     (i_r),
        .i_sense (i_sense),
        .o_event (w_event)
    );

    assign w_leakTerm = (r_leakCnt == LEAK_LAST);
`ifndef CITADEL_SENTINEL_LATCH_EN
    assign w_coolDone = (r_coolCnt == COOL_DONE);
`endif

    // Candidate event count for this ARMED cycle: an event adds one, a leak
    // terminal without an event removes one, and both together cancel out.
    always_comb begin
        w_countNext = r_count;
        if (w_event && !w_leakTerm) begin
            w_countNext = satInc(r_count);
        end else if (!w_event && w_leakTerm && (r_count != '0)) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    assign w_trigger = (w_countNext >= THRESH_C) || i_force;

    // Controller FSM with its timers and registered outputs; timers sit at zero
    // outside their own state so every state entry starts them from zero.
    always_ff @(posedge i_clk) begin
        if (i_r) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_leakCnt <= '0;
            r_wipeCnt <= '0;
            r_wipe    <= 1'b0;
            r_alert   <= 1'b0;
            r_locked  <= 1'b0;
`ifndef CITADEL_SENTINEL_LATCH_EN
            r_coolCnt <= '0;
`endif
        end else begin
            r_leakCnt <= '0;
            r_wipeCnt <= '0;
            r_wipe    <= 1'b0;
            r_alert   <= 1'b0;
            r_locked  <= 1'b0;
`ifndef CITADEL_SENTINEL_LATCH_EN
            r_coolCnt <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    if (i_force) begin
                        r_state <= ST_WIPE;
                        r_wipe  <= 1'b1;
                    end else if (i_arm) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trigger) begin
                        r_state <= ST_WIPE;
                        r_count <= '0;
                        r_wipe  <= 1'b1;
                    end else if (!i_arm) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count   <= w_countNext;
                        r_alert   <= (w_countNext != '0);
                        r_leakCnt <= w_leakTerm ? '0 : r_leakCnt + LEAK_W'(1);
                    end
                end
                ST_WIPE: begin
                    r_count <= '0;
                    if (r_wipeCnt == WIPE_LAST) begin
                        r_state  <= ST_LOCKOUT;
                        r_locked <= 1'b1;
                    end else begin
                        r_wipe    <= 1'b1;
                        r_wipeCnt <= r_wipeCnt + WIPE_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    r_count <= '0;
`ifdef CITADEL_SENTINEL_LATCH_EN
                    r_locked <= 1'b1;
`else
                    if (i_force) begin
                        r_state <= ST_WIPE;
                        r_wipe  <= 1'b1;
                    end else if (i_ack && w_coolDone) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_locked  <= 1'b1;
                        r_coolCnt <= w_coolDone ? r_coolCnt : r_coolCnt + COOL_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign o_wipe      = r_wipe;
    assign o_alert     = r_alert;
    assign o_locked    = r_locked;
    assign o_state     = r_state;
    assign o_evt_count = r_count;

endmodule

// File: tb/tb_sentinel_guard_ctrl.sv
// tb_sentinel_guard_ctrl: self-checking bench for sentinel_guard_ctrl.
// A behavioural model built from sensor-sample history and per-state cycle ages
// is compared every cycle, alongside table vectors and directed sequences.
// Honours CITADEL_SENTINEL_LATCH_EN for the terminal-lockout build.
`timescale 1ns/1ps
module tb_sentinel_guard_ctrl;

    localparam int N_SENSE  = 4;
    localparam int THRESH   = 3;
    localparam int WINDOW   = 64;
    localparam int WIPE_CYC = 8;
    localparam int COOL_CYC = 256;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_WIPE  = 2;
    localparam int S_LOCK  = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic               arm;
    logic [N_SENSE-1:0] sense;
    logic               forceReq;
    logic               ack;
    logic               wipe;
    logic               alert;
    logic               locked;
    logic [1:0]         state;
    logic [3:0]         evtCount;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int                 mMode  = 0;
    int                 mCount = 0;
    int                 mAge   = 0;
    int                 mCyc   = 0;
    int                 mNext;
    bit                 mTerm;
    bit                 mEvt;
    logic [N_SENSE-1:0] mHist [0:4] = '{default: '0};

    typedef struct {
        string      name;
        logic [3:0] mask;
        int         pulses;
        int         hold;
        int         gap;
        int         expCount;
        int         expState;
        int         expAlert;
        int         expWipe;
    } vec_t;

    vec_t vecs [7];

    sentinel_guard_ctrl #(
        .N_SENSE  (N_SENSE),
        .THRESH   (THRESH),
        .WINDOW   (WINDOW),
        .WIPE_CYC (WIPE_CYC),
        .COOL_CYC (COOL_CYC)
    ) dut (
        .i_clk       (clock),
        .i_r         (reset),
        .i_arm       (arm),
        .i_sense     (sense),
        .i_force     (forceReq),
        .i_ack       (ack),
        .o_wipe      (wipe),
        .o_alert     (alert),
        .o_locked    (locked),
        .o_state     (state),
        .o_evt_count (evtCount)
    );

    always #5 clock = ~clock;

    task automatic modelEnter(input int m);
        mMode = m;
        mAge  = 0;
        if (m != S_ARMED) mCount = 0;
    endtask

    // Behavioural model: an event is a bit that was low three edges ago and high
    // two edges ago in the sampled history, ignored in the first four edges after reset.
    always @(posedge clock) begin
        if (reset) begin
            mMode  = S_IDLE;
            mCount = 0;
            mAge   = 0;
            mCyc   = 0;
            for (int i = 0; i < 5; i++) mHist[i] = '0;
        end else begin
            for (int i = 4; i > 0; i--) mHist[i] = mHist[i-1];
            mHist[0] = sense;
            mCyc = mCyc + 1;
            mEvt = (mCyc >= 5) && ((mHist[3] & ~mHist[4]) != '0);
            mAge = mAge + 1;
            case (mMode)
                S_IDLE: begin
                    if (forceReq) modelEnter(S_WIPE);
                    else if (arm) modelEnter(S_ARMED);
                end
                S_ARMED: begin
                    mTerm = (mAge % WINDOW) == 0;
                    mNext = mCount;
                    if (mEvt && !mTerm) mNext = (mCount < 15) ? mCount + 1 : 15;
                    else if (!mEvt && mTerm && mCount > 0) mNext = mCount - 1;
                    if (mNext >= THRESH || forceReq) modelEnter(S_WIPE);
                    else if (!arm) modelEnter(S_IDLE);
                    else mCount = mNext;
                end
                S_WIPE: begin
                    if (mAge >= WIPE_CYC) modelEnter(S_LOCK);
                end
                default: begin
`ifndef CITADEL_SENTINEL_LATCH_EN
                    if (forceReq) modelEnter(S_WIPE);
                    else if (ack && mAge > COOL_CYC) modelEnter(S_IDLE);
`endif
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        int eWipe, eAlert, eLocked;
        eWipe   = (mMode == S_WIPE);
        eLocked = (mMode == S_LOCK);
        eAlert  = (mMode == S_ARMED) && (mCount != 0);
        vectors++;
        if (int'(state) != mMode || int'(evtCount) != mCount || int'(wipe) != eWipe ||
            int'(alert) != eAlert || int'(locked) != eLocked) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t: got st=%0d cnt=%0d wipe=%0b alert=%0b lock=%0b, expected st=%0d cnt=%0d wipe=%0d alert=%0d lock=%0d",
                     $time, state, evtCount, wipe, alert, locked, mMode, mCount, eWipe, eAlert, eLocked);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        checkModel();
    endtask

    task automatic doReset();
        reset    = 1'b1;
        arm      = 1'b0;
        sense    = '0;
        forceReq = 1'b0;
        ack      = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic sensePulse(input logic [3:0] mask, input int hold, input int gap);
        sense = mask;
        repeat (hold) tick();
        sense = '0;
        repeat (gap) tick();
    endtask

    task automatic applyStimulus();
        reset    = ($urandom_range(0, 999) == 0);
        if ($urandom_range(0, 63) == 0) arm = ~arm;
        if ($urandom_range(0, 7) == 0) sense = sense ^ (N_SENSE'(1) << $urandom_range(0, N_SENSE - 1));
        forceReq = ($urandom_range(0, 299) == 0);
        ack      = ($urandom_range(0, 15) == 0);
        tick();
    endtask

    initial begin
        vecs[0] = '{"single",    4'b0001, 1, 1, 4, 1, S_ARMED, 1, 0};
        vecs[1] = '{"all4x2",    4'b1111, 2, 1, 4, 2, S_ARMED, 1, 0};
        vecs[2] = '{"simult",    4'b0011, 1, 1, 4, 1, S_ARMED, 1, 0};
        vecs[3] = '{"held",      4'b0100, 1, 8, 4, 1, S_ARMED, 1, 0};
        vecs[4] = '{"gap1",      4'b1000, 2, 1, 1, 2, S_ARMED, 1, 0};
        vecs[5] = '{"thresh",    4'b0001, 3, 1, 4, 0, S_WIPE,  0, 1};
        vecs[6] = '{"ignwipe",   4'b0010, 4, 1, 4, 0, S_LOCK,  0, 0};

        reset = 1'b1; arm = 1'b0; sense = '0; forceReq = 1'b0; ack = 1'b0;
        tick();
        checkOutput("reset/state", state, S_IDLE);
        checkOutput("reset/wipe", wipe, 0);
        checkOutput("reset/alert", alert, 0);
        checkOutput("reset/locked", locked, 0);
        checkOutput("reset/count", evtCount, 0);

        // Table vectors, each from a fresh reset with arm held high
        for (int v = 0; v < 7; v++) begin
            doReset();
            arm = 1'b1;
            repeat (5) tick();
            for (int p = 0; p < vecs[v].pulses; p++) sensePulse(vecs[v].mask, vecs[v].hold, vecs[v].gap);
            repeat (6) tick();
            checkOutput({vecs[v].name, "/count"}, evtCount, vecs[v].expCount);
            checkOutput({vecs[v].name, "/state"}, state, vecs[v].expState);
            checkOutput({vecs[v].name, "/alert"}, alert, vecs[v].expAlert);
            checkOutput({vecs[v].name, "/wipe"}, wipe, vecs[v].expWipe);
        end

        // Three pulses five cycles apart: exact wipe window and lockout
        doReset();
        arm = 1'b1;
        repeat (5) tick();
        sensePulse(4'b0001, 1, 4);
        checkOutput("seqA/alert1", alert, 1);
        sensePulse(4'b0001, 1, 4);
        checkOutput("seqA/count2", evtCount, 2);
        sensePulse(4'b0001, 1, 2);
        checkOutput("seqA/preWipe", wipe, 0);
        for (int i = 0; i < WIPE_CYC; i++) begin
            tick();
            checkOutput($sformatf("seqA/wipe%0d", i), wipe, 1);
        end
        tick();
        checkOutput("seqA/wipeEnd", wipe, 0);
        checkOutput("seqA/locked", locked, 1);

        // Leak: two events decay away over two windows without a wipe
        doReset();
        arm = 1'b1;
        repeat (5) tick();
        sensePulse(4'b0001, 1, 4);
        sensePulse(4'b0001, 1, 0);
        repeat (29) tick();
        checkOutput("leak/count2", evtCount, 2);
        repeat (60) tick();
        checkOutput("leak/count1", evtCount, 1);
        repeat (40) tick();
        checkOutput("leak/count0", evtCount, 0);
        checkOutput("leak/alert0", alert, 0);
        checkOutput("leak/state", state, S_ARMED);

        // All four sensors rising together count once per rise
        doReset();
        arm = 1'b1;
        repeat (5) tick();
        sensePulse(4'b1111, 1, 4);
        checkOutput("all4/count1", evtCount, 1);
        sensePulse(4'b1111, 1, 4);
        checkOutput("all4/count2", evtCount, 2);
        sensePulse(4'b1111, 1, 3);
        checkOutput("all4/wipe", wipe, 1);

        // Forced wipe from IDLE, then lockout cooldown and ack handling
        doReset();
        tick();
        forceReq = 1'b1;
        tick();
        forceReq = 1'b0;
        checkOutput("forceIdle/wipe", wipe, 1);
        repeat (WIPE_CYC - 1) tick();
        checkOutput("forceIdle/lastWipe", wipe, 1);
        tick();
        checkOutput("forceIdle/wipeEnd", wipe, 0);
        checkOutput("forceIdle/locked", locked, 1);
        repeat (99) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        checkOutput("ack100/locked", locked, 1);
        repeat (155) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        checkOutput("ack256/locked", locked, 1);
        ack = 1'b1; tick(); ack = 1'b0;
`ifdef CITADEL_SENTINEL_LATCH_EN
        checkOutput("ack257/locked", locked, 1);
        checkOutput("ack257/state", state, S_LOCK);
        repeat (1000) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        checkOutput("latch/ack1000", state, S_LOCK);
        forceReq = 1'b1; tick(); forceReq = 1'b0;
        checkOutput("latch/forceWipe", wipe, 0);
        checkOutput("latch/forceState", state, S_LOCK);
`else
        checkOutput("ack257/locked", locked, 0);
        checkOutput("ack257/state", state, S_IDLE);
        arm = 1'b1;
        tick();
        checkOutput("rearm/state", state, S_ARMED);

        // Force from ARMED into lockout, force again, then reset mid-wipe
        forceReq = 1'b1; tick(); forceReq = 1'b0;
        checkOutput("forceArmed/wipe", wipe, 1);
        repeat (WIPE_CYC) tick();
        checkOutput("forceArmed/locked", locked, 1);
        forceReq = 1'b1; tick(); forceReq = 1'b0;
        checkOutput("forceLock/wipe", wipe, 1);
        checkOutput("forceLock/locked", locked, 0);
        repeat (2) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("midWipeReset/wipe", wipe, 0);
        checkOutput("midWipeReset/state", state, S_IDLE);
`endif

        // Sensor held high across reset release must not count
        reset = 1'b1; arm = 1'b0; sense = 4'b0010; forceReq = 1'b0; ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        arm = 1'b1;
        repeat (10) tick();
        checkOutput("heldReset/count", evtCount, 0);
        checkOutput("heldReset/alert", alert, 0);
        sense = '0;
        repeat (3) tick();
        sensePulse(4'b0010, 1, 4);
        checkOutput("heldReset/newRise", evtCount, 1);

        // Random run checked cycle by cycle against the model
        doReset();
        arm = 1'b1;
        for (int c = 0; c < 4000; c++) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
